// File: rtl/weight_stream_source_if.sv
// Streamer bus: ROM read port toward the parameter ROM wrapper and the
// valid/ready block stream toward the consuming core.
interface weight_stream_source_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned P          = 1,
  parameter int unsigned AW         = 6
);
  logic [AW-1:0]           rom_addr;
  logic                    rom_ce;
  logic [DATA_WIDTH*P-1:0] rom_q;
  logic [DATA_WIDTH-1:0]   data_out [P];
  logic                    data_out_valid;
  logic                    data_out_ready;

  modport master (
    output rom_addr, rom_ce, data_out, data_out_valid,
    input  rom_q, data_out_ready
  );

  modport slave (
    input  rom_addr, rom_ce, data_out, data_out_valid,
    output rom_q, data_out_ready
  );
endinterface

// File: rtl/weight_stream_source.sv
// Streams a ROM-resident tensor block by block over valid/ready, tracking
// ROM read latency with credits so back-pressure never drops or repeats a word.
module weight_stream_source #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned TENSOR_SIZE_DIM_0 = 32,
  parameter int unsigned TENSOR_SIZE_DIM_1 = 1,
  parameter int unsigned PARALLELISM_DIM_0 = 1,
  parameter int unsigned PARALLELISM_DIM_1 = 1,
  parameter int unsigned ROM_LATENCY       = 2,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned REPEAT            = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  weight_stream_source_if.master bus
);
  localparam int unsigned BLOCKS    = (TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0) *
                                      (TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1);
  localparam int unsigned P         = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int unsigned AW        = $clog2(BLOCKS) + 1;
  localparam int unsigned WW        = DATA_WIDTH * P;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int unsigned LAST_PASS = (REPEAT == 0) ? 0 : REPEAT - 1;
  localparam bit          ENDLESS   = (REPEAT == 0);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                 state_q;
  logic [AW-1:0]          addr_q;
  logic [AW-1:0]          next_addr_q, next_addr_d;
  logic [31:0]            pass_q, pass_d;
  logic                   issue_q;
  logic [ROM_LATENCY-1:0] tag_q;
  logic [CW-1:0]          in_flight_q, in_flight_d;
  logic [CW-1:0]          fifo_count_q, fifo_count_d;
  logic [WW-1:0]          fifo_q [FIFO_DEPTH];
  logic [WW-1:0]          fifo_d [FIFO_DEPTH];
  logic                   valid_q, busy_q, done_q, ce_q;

  logic                   push, pop, credit_ok, do_issue, wrap, last_issue, drain_end;
  logic [AW-1:0]          base_addr;
  logic [31:0]            base_pass;

  // Issue credit, address/pass sequencing and the shift-register output FIFO.
  always_comb begin
    push      = tag_q[ROM_LATENCY-1];
    pop       = valid_q && bus.data_out_ready;
    // A same-cycle pop frees a slot, which keeps a FIFO_DEPTH = latency+2 buffer bubble-free.
    credit_ok = ({1'b0, in_flight_q} + {1'b0, fifo_count_q}) <
                ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));
    do_issue  = ((state_q == IDLE) && start_i) || ((state_q == RUN) && credit_ok);
    base_addr = (state_q == IDLE) ? '0 : next_addr_q;
    base_pass = (state_q == IDLE) ? '0 : pass_q;
    wrap       = (base_addr == AW'(BLOCKS - 1));
    last_issue = do_issue && wrap && !ENDLESS && (base_pass == 32'(LAST_PASS));

    next_addr_d = next_addr_q;
    pass_d      = pass_q;
    if (do_issue) begin
      next_addr_d = wrap ? '0 : base_addr + AW'(1);
      pass_d      = wrap ? base_pass + 32'd1 : base_pass;
    end

    in_flight_d  = in_flight_q + CW'(do_issue) - CW'(push);
    fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
    drain_end    = (state_q == DRAIN) && (in_flight_d == '0) && (fifo_count_d == '0);

    for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_d[i] = fifo_q[i];
    if (pop) begin
      for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) fifo_d[i] = fifo_q[i + 1];
    end
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (push && (CW'(i) == fifo_count_q - CW'(pop))) fifo_d[i] = bus.rom_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      next_addr_q  <= '0;
      pass_q       <= '0;
      issue_q      <= 1'b0;
      tag_q        <= '0;
      in_flight_q  <= '0;
      fifo_count_q <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ce_q         <= 1'b1;
    end else begin
      ce_q         <= 1'b1;
      issue_q      <= do_issue;
      tag_q        <= ROM_LATENCY'({tag_q, issue_q});
      next_addr_q  <= next_addr_d;
      pass_q       <= pass_d;
      in_flight_q  <= in_flight_d;
      fifo_count_q <= fifo_count_d;
      valid_q      <= (fifo_count_d != '0);
      done_q       <= drain_end;
      if (do_issue) addr_q <= base_addr;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= last_issue ? DRAIN : RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (last_issue) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drain_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffered words carry no reset: valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
  end

  assign bus.rom_addr       = addr_q;
  assign bus.rom_ce         = ce_q;
  assign bus.data_out_valid = valid_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

  for (genvar j = 0; j < int'(P); j++) begin : g_lane
    assign bus.data_out[j] = fifo_q[0][j*DATA_WIDTH +: DATA_WIDTH];
  end
endmodule

// File: tb/tb_weight_stream_source.sv
// Bench for weight_stream_source: three configurations driven with directed
// and random back-pressure, checked against a block-sequence reference model.
module tb_weight_stream_source;
  localparam int unsigned L0 = 2, B0 = 32, R0 = 1;
  localparam int unsigned L1 = 3, B1 = 4,  R1 = 3;
  localparam int unsigned L2 = 1, B2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ROM contents: word k of each configuration
  function automatic logic [15:0] w0(input int unsigned k);
    return 16'(k);
  endfunction
  function automatic logic [31:0] w1(input int unsigned k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(32'h11 * (j + 1) + k);
    return w;
  endfunction
  function automatic logic [15:0] w2(input int unsigned k);
    return 16'(k * 257 + 165);
  endfunction

  logic start0 = 0, start1 = 0, start2 = 0;
  logic ready0 = 0, ready1 = 0, ready2 = 0;
  logic rnd0 = 0, rnd1 = 0, rnd2 = 0;
  logic busy0, busy1, busy2, done0, done1, done2;

  weight_stream_source_if #(.DATA_WIDTH(16), .P(1), .AW(6)) if0 ();
  weight_stream_source_if #(.DATA_WIDTH(8),  .P(4), .AW(3)) if1 ();
  weight_stream_source_if #(.DATA_WIDTH(16), .P(1), .AW(3)) if2 ();

  weight_stream_source u0 (
    .clk(clk), .rst(rst), .start_i(start0), .busy_o(busy0), .done_o(done0), .bus(if0)
  );
  weight_stream_source #(
    .DATA_WIDTH(8), .TENSOR_SIZE_DIM_0(16), .PARALLELISM_DIM_0(4),
    .ROM_LATENCY(L1), .FIFO_DEPTH(5), .REPEAT(R1)
  ) u1 (
    .clk(clk), .rst(rst), .start_i(start1), .busy_o(busy1), .done_o(done1), .bus(if1)
  );
  weight_stream_source #(
    .TENSOR_SIZE_DIM_0(4), .ROM_LATENCY(L2), .FIFO_DEPTH(3), .REPEAT(0)
  ) u2 (
    .clk(clk), .rst(rst), .start_i(start2), .busy_o(busy2), .done_o(done2), .bus(if2)
  );

  // Synchronous ROMs with the configured read latency
  logic [15:0] rp0 [L0];
  logic [31:0] rp1 [L1];
  logic [15:0] rp2 [L2];
  always @(posedge clk) begin
    rp0[0] <= w0(32'(if0.rom_addr));
    for (int i = 1; i < int'(L0); i++) rp0[i] <= rp0[i-1];
    rp1[0] <= w1(32'(if1.rom_addr));
    for (int i = 1; i < int'(L1); i++) rp1[i] <= rp1[i-1];
    rp2[0] <= w2(32'(if2.rom_addr));
  end
  assign if0.rom_q = rp0[L0-1];
  assign if1.rom_q = rp1[L1-1];
  assign if2.rom_q = rp2[L2-1];
  assign if0.data_out_ready = ready0;
  assign if1.data_out_ready = ready1;
  assign if2.data_out_ready = ready2;

  // Reference: output n of a run is ROM word (n mod BLOCKS); busy spans start
  // acceptance to done; done follows the final handshake by one cycle.
  logic exp_busy0 = 0, exp_done0 = 0, pv0 = 0, pr0 = 0, prst0 = 1;
  logic [15:0] pd0 = '0;
  int unsigned idx0 = 0, pops0 = 0, dones0 = 0;
  always @(negedge clk) begin : mon0
    logic pop, fin;
    check("busy0", 64'(busy0), 64'(exp_busy0));
    check("done0", 64'(done0), 64'(exp_done0));
    check("rom_ce0", 64'(if0.rom_ce), 64'd1);
    if (done0) dones0++;
    if (!exp_busy0) check("idle_valid0", 64'(if0.data_out_valid), 64'd0);
    if (pv0 && !pr0 && !prst0) begin
      check("hold_valid0", 64'(if0.data_out_valid), 64'd1);
      check("hold_data0", 64'(if0.data_out[0]), 64'(pd0));
    end
    pop = if0.data_out_valid && ready0;
    fin = 1'b0;
    if (pop) begin
      check("data0", 64'(if0.data_out[0]), 64'(w0(idx0 % B0)));
      idx0++; pops0++;
      fin = (idx0 == B0 * R0);
    end
    if (rst) begin exp_busy0 = 0; exp_done0 = 0; end
    else if (!exp_busy0) begin exp_done0 = 0; if (start0) begin exp_busy0 = 1; idx0 = 0; end end
    else begin exp_done0 = fin; exp_busy0 = !fin; end
    pv0 = if0.data_out_valid; pr0 = ready0; pd0 = if0.data_out[0]; prst0 = rst;
  end

  logic exp_busy1 = 0, exp_done1 = 0, pv1 = 0, pr1 = 0, prst1 = 1;
  logic [31:0] pd1 = '0;
  int unsigned idx1 = 0, pops1 = 0, dones1 = 0;
  always @(negedge clk) begin : mon1
    logic pop, fin;
    logic [31:0] act;
    for (int j = 0; j < 4; j++) act[j*8 +: 8] = if1.data_out[j];
    check("busy1", 64'(busy1), 64'(exp_busy1));
    check("done1", 64'(done1), 64'(exp_done1));
    if (done1) dones1++;
    if (!exp_busy1) check("idle_valid1", 64'(if1.data_out_valid), 64'd0);
    if (pv1 && !pr1 && !prst1) begin
      check("hold_valid1", 64'(if1.data_out_valid), 64'd1);
      check("hold_data1", 64'(act), 64'(pd1));
    end
    pop = if1.data_out_valid && ready1;
    fin = 1'b0;
    if (pop) begin
      check("data1", 64'(act), 64'(w1(idx1 % B1)));
      idx1++; pops1++;
      fin = (idx1 == B1 * R1);
    end
    if (rst) begin exp_busy1 = 0; exp_done1 = 0; end
    else if (!exp_busy1) begin exp_done1 = 0; if (start1) begin exp_busy1 = 1; idx1 = 0; end end
    else begin exp_done1 = fin; exp_busy1 = !fin; end
    pv1 = if1.data_out_valid; pr1 = ready1; pd1 = act; prst1 = rst;
  end

  logic exp_busy2 = 0, pv2 = 0, pr2 = 0, prst2 = 1;
  logic [15:0] pd2 = '0;
  int unsigned idx2 = 0, pops2 = 0;
  always @(negedge clk) begin : mon2
    check("busy2", 64'(busy2), 64'(exp_busy2));
    check("done2", 64'(done2), 64'd0);
    if (!exp_busy2) check("idle_valid2", 64'(if2.data_out_valid), 64'd0);
    if (pv2 && !pr2 && !prst2) check("hold_data2", 64'(if2.data_out[0]), 64'(pd2));
    if (if2.data_out_valid && ready2) begin
      check("data2", 64'(if2.data_out[0]), 64'(w2(idx2 % B2)));
      idx2++; pops2++;
    end
    if (rst) exp_busy2 = 0;
    else if (!exp_busy2 && start2) begin exp_busy2 = 1; idx2 = 0; end
    pv2 = if2.data_out_valid; pr2 = ready2; pd2 = if2.data_out[0]; prst2 = rst;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd0) ready0 = 1'($urandom_range(0, 1));
      if (rnd1) ready1 = 1'($urandom_range(0, 1));
      if (rnd2) ready2 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_done(input int which, input int unsigned bound, input string name);
    int unsigned n = 0;
    while (n < bound && !((which == 0) ? done0 : done1)) begin tick(1); n++; end
    check(name, 64'((which == 0) ? done0 : done1), 64'd1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached, got no summary expected summary");
    $fatal(1);
  end

  initial begin : stim
    int unsigned p0, d0, n;
    rst = 1'b1; ready0 = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_valid", 64'(if0.data_out_valid), 64'd0);
    check("rst_addr", 64'(if0.rom_addr), 64'd0);
    check("rst_ce", 64'(if0.rom_ce), 64'd1);
    tick(1);

    // Full-rate pass: start at edge t, valid from cycle t+4, words 0..31 back to back
    start0 = 1'b1; tick(1); start0 = 1'b0;
    check("t1_busy", 64'(busy0), 64'd1);
    check("t1_valid", 64'(if0.data_out_valid), 64'd0);
    check("t1_addr", 64'(if0.rom_addr), 64'd0);
    tick(1);
    check("t2_addr", 64'(if0.rom_addr), 64'd1);
    tick(1);
    check("t3_valid", 64'(if0.data_out_valid), 64'd0);
    tick(1);
    for (int unsigned k = 0; k < 32; k++) begin
      check("stream_valid", 64'(if0.data_out_valid), 64'd1);
      check("stream_word", 64'(if0.data_out[0]), 64'(k));
      tick(1);
    end
    check("final_done", 64'(done0), 64'd1);
    check("final_busy", 64'(busy0), 64'd0);
    tick(1);
    check("done_pulse", 64'(done0), 64'd0);

    // Random back-pressure
    p0 = pops0; rnd0 = 1'b1;
    start0 = 1'b1; tick(1); start0 = 1'b0;
    wait_done(0, 3000, "rand_done0");
    check("rand_count0", 64'(pops0 - p0), 64'd32);
    rnd0 = 1'b0; ready0 = 1'b1; tick(3);

    // Reset mid-run with a full buffer
    ready0 = 1'b0;
    start0 = 1'b1; tick(1); start0 = 1'b0;
    tick(8);
    check("fill_valid", 64'(if0.data_out_valid), 64'd1);
    check("fill_head", 64'(if0.data_out[0]), 64'd0);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("mid_rst_valid", 64'(if0.data_out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy0), 64'd0);
    tick(6);
    check("post_rst_valid", 64'(if0.data_out_valid), 64'd0);
    p0 = pops0; ready0 = 1'b1;
    start0 = 1'b1; tick(1); start0 = 1'b0;
    wait_done(0, 200, "restart_done");
    check("restart_count", 64'(pops0 - p0), 64'd32);
    tick(2);

    // Start pulsed while busy is ignored
    p0 = pops0; d0 = dones0;
    start0 = 1'b1; tick(1); start0 = 1'b0;
    tick(5);
    start0 = 1'b1; tick(1); start0 = 1'b0;
    wait_done(0, 200, "busy_start_done");
    tick(10);
    check("busy_start_count", 64'(pops0 - p0), 64'd32);
    check("busy_start_dones", 64'(dones0 - d0), 64'd1);

    // Wide blocks with REPEAT=3, endless stream alongside
    ready1 = 1'b0; rnd2 = 1'b1;
    start1 = 1'b1; start2 = 1'b1; tick(1); start1 = 1'b0; start2 = 1'b0;
    n = 0;
    while (n < 20 && !if1.data_out_valid) begin tick(1); n++; end
    check("lane_valid", 64'(if1.data_out_valid), 64'd1);
    check("lane0", 64'(if1.data_out[0]), 64'h11);
    check("lane1", 64'(if1.data_out[1]), 64'h22);
    check("lane3", 64'(if1.data_out[3]), 64'h44);
    rnd1 = 1'b1;
    wait_done(1, 2000, "repeat_done");
    tick(5);
    check("repeat_count", 64'(pops1), 64'(B1 * R1));
    check("repeat_dones", 64'(dones1), 64'd1);
    n = 0;
    while (n < 3000 && pops2 <= 100) begin tick(1); n++; end
    check("endless_count", 64'(pops2 > 100), 64'd1);
    check("endless_busy", 64'(busy2), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
